// File: rtl/phaethon_cpu_if.sv
// Phaethon CPU bus bundle: RAM port, UART handshakes and debug taps.
// Signal names follow the core's external pin names.
interface phaethon_cpu_if;
    logic [31:0] ramIn;
    logic [31:0] ramAddress;
    logic [31:0] ramOut;
    logic        readReq;
    logic        writeReq;
    logic        uartReadReq;
    logic        uartReadAck;
    logic [7:0]  uartReadData;
    logic        uartWriteReq;
    logic [7:0]  uartWriteData;
    logic        uartWriteReady;
    logic [31:0] debug;
    logic [31:0] debug2;
    logic [8:0]  debug3;

    modport master (
        input  ramIn, uartReadAck, uartReadData, uartWriteReady,
        output ramAddress, ramOut, readReq, writeReq, uartReadReq,
               uartWriteReq, uartWriteData, debug, debug2, debug3
    );

    modport slave (
        output ramIn, uartReadAck, uartReadData, uartWriteReady,
        input  ramAddress, ramOut, readReq, writeReq, uartReadReq,
               uartWriteReq, uartWriteData, debug, debug2, debug3
    );
endinterface

// File: rtl/phaethon_cpu.sv
// Phaethon multi-cycle 32-bit CPU core.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | one dead cycle after reset
// FETCH      | read strobe for instruction word at PC
// DECODE     | capture instruction fields from RAM data
// IMM_REQ    | read strobe for imm32 word at PC+4
// IMM_LAT    | capture imm32
// EXEC       | ALU / branch / dispatch to multi-cycle ops
// MEM_REQ    | LD: read strobe at rB
// MEM_WB     | LD: write RAM data to rA
// MEM_WR     | ST: one-cycle write strobe
// URD        | UARTRD: request held until ack is sampled
// UWR        | UARTWR: wait for sender ready
// UWR_SEND   | UARTWR: single send strobe
// HALTED     | terminal, only reset leaves
module phaethon_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic clk,
    input  logic reset,
    phaethon_cpu_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_IMM_REQ, S_IMM_LAT, S_EXEC, S_MEM_REQ,
        S_MEM_WB, S_MEM_WR, S_URD, S_UWR, S_UWR_SEND, S_HALTED
    } state_t;

    localparam logic [7:0] OP_MOVI  = 8'h01;
    localparam logic [7:0] OP_MOV   = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_AND   = 8'h05;
    localparam logic [7:0] OP_OR    = 8'h06;
    localparam logic [7:0] OP_XOR   = 8'h07;
    localparam logic [7:0] OP_SHL   = 8'h08;
    localparam logic [7:0] OP_SHR   = 8'h09;
    localparam logic [7:0] OP_LD    = 8'h0A;
    localparam logic [7:0] OP_ST    = 8'h0B;
    localparam logic [7:0] OP_JMP   = 8'h0C;
    localparam logic [7:0] OP_JZ    = 8'h0D;
    localparam logic [7:0] OP_JNZ   = 8'h0E;
    localparam logic [7:0] OP_URD   = 8'h0F;
    localparam logic [7:0] OP_UWR   = 8'h10;
    localparam logic [7:0] OP_ADDI  = 8'h11;
    localparam logic [7:0] OP_CMPLT = 8'h12;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] imm, imm_next;
    // only the decoded instruction fields are kept; bits [23:20] and [15:12] are don't-care
    logic [7:0]  op_r, op_next;
    logic [3:0]  ra_r, ra_next;
    logic [3:0]  rb_r, rb_next;
    logic [7:0]  imm8_r, imm8_next;
    logic [31:0] regs [16];
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] va, vb;

    assign va = regs[ra_r];
    assign vb = regs[rb_r];

    function automatic logic has_imm32(input logic [7:0] op);
        return (op == OP_MOVI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JNZ);
    endfunction

    // state and architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            imm    <= '0;
            op_r   <= '0;
            ra_r   <= '0;
            rb_r   <= '0;
            imm8_r <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            imm    <= imm_next;
            op_r   <= op_next;
            ra_r   <= ra_next;
            rb_r   <= rb_next;
            imm8_r <= imm8_next;
        end
    end

    // register file; the only write port targets rA
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[ra_r] <= wr_data;
        end
    end

    // next state, next PC and register write-back
    always_comb begin
        state_next = state;
        pc_next    = pc;
        imm_next   = imm;
        op_next    = op_r;
        ra_next    = ra_r;
        rb_next    = rb_r;
        imm8_next  = imm8_r;
        wr_en      = 1'b0;
        wr_data    = '0;
        case (state)
            S_IDLE:    state_next = S_FETCH;
            S_FETCH:   state_next = S_DECODE;
            S_DECODE: begin
                op_next    = bus.ramIn[7:0];
                ra_next    = bus.ramIn[11:8];
                rb_next    = bus.ramIn[19:16];
                imm8_next  = bus.ramIn[31:24];
                state_next = has_imm32(bus.ramIn[7:0]) ? S_IMM_REQ : S_EXEC;
            end
            S_IMM_REQ: state_next = S_IMM_LAT;
            S_IMM_LAT: begin
                imm_next   = bus.ramIn;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                pc_next    = pc + 32'd4;
                case (op_r)
                    OP_MOVI:  begin wr_en = 1'b1; wr_data = imm; pc_next = pc + 32'd8; end
                    OP_MOV:   begin wr_en = 1'b1; wr_data = vb; end
                    OP_ADD:   begin wr_en = 1'b1; wr_data = va + vb; end
                    OP_SUB:   begin wr_en = 1'b1; wr_data = va - vb; end
                    OP_AND:   begin wr_en = 1'b1; wr_data = va & vb; end
                    OP_OR:    begin wr_en = 1'b1; wr_data = va | vb; end
                    OP_XOR:   begin wr_en = 1'b1; wr_data = va ^ vb; end
                    OP_SHL:   begin wr_en = 1'b1; wr_data = va << vb[4:0]; end
                    OP_SHR:   begin wr_en = 1'b1; wr_data = va >> vb[4:0]; end
                    OP_ADDI:  begin wr_en = 1'b1; wr_data = va + {{24{imm8_r[7]}}, imm8_r}; end
                    OP_CMPLT: begin wr_en = 1'b1; wr_data = {31'b0, va < vb}; end
                    OP_JMP:   pc_next = imm;
                    OP_JZ:    pc_next = (va == 32'd0) ? imm : pc + 32'd8;
                    OP_JNZ:   pc_next = (va != 32'd0) ? imm : pc + 32'd8;
                    OP_LD:    begin pc_next = pc; state_next = S_MEM_REQ; end
                    OP_ST:    begin pc_next = pc; state_next = S_MEM_WR; end
                    OP_URD:   begin pc_next = pc; state_next = S_URD; end
                    OP_UWR:   begin pc_next = pc; state_next = S_UWR; end
                    OP_HALT:  begin pc_next = pc; state_next = S_HALTED; end
                    default:  ;
                endcase
            end
            S_MEM_REQ: state_next = S_MEM_WB;
            S_MEM_WB: begin
                wr_en      = 1'b1;
                wr_data    = bus.ramIn;
                pc_next    = pc + 32'd4;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                pc_next    = pc + 32'd4;
                state_next = S_FETCH;
            end
            S_URD: begin
                if (bus.uartReadAck) begin
                    wr_en      = 1'b1;
                    wr_data    = {24'h0, bus.uartReadData};
                    pc_next    = pc + 32'd4;
                    state_next = S_FETCH;
                end
            end
            S_UWR: begin
                if (bus.uartWriteReady) state_next = S_UWR_SEND;
            end
            S_UWR_SEND: begin
                pc_next    = pc + 32'd4;
                state_next = S_FETCH;
            end
            S_HALTED: state_next = S_HALTED;
            default:  state_next = S_IDLE;
        endcase
    end

    // Moore output decode from registered state only
    always_comb begin
        bus.readReq       = 1'b0;
        bus.writeReq      = 1'b0;
        bus.ramAddress    = '0;
        bus.ramOut        = '0;
        bus.uartReadReq   = 1'b0;
        bus.uartWriteReq  = 1'b0;
        bus.uartWriteData = '0;
        case (state)
            S_FETCH:    begin bus.readReq = 1'b1; bus.ramAddress = pc; end
            S_IMM_REQ:  begin bus.readReq = 1'b1; bus.ramAddress = pc + 32'd4; end
            S_MEM_REQ:  begin bus.readReq = 1'b1; bus.ramAddress = vb; end
            S_MEM_WR:   begin bus.writeReq = 1'b1; bus.ramAddress = vb; bus.ramOut = va; end
            S_URD:      bus.uartReadReq = 1'b1;
            S_UWR_SEND: begin bus.uartWriteReq = 1'b1; bus.uartWriteData = va[7:0]; end
            default:    ;
        endcase
    end

    assign bus.debug  = pc;
    assign bus.debug2 = regs[1];
    assign bus.debug3 = {state == S_HALTED, op_r};
endmodule

// File: tb/tb_phaethon_cpu.sv
// Bench for phaethon_cpu: RAM/UART models, an instruction-level reference
// model feeding a scoreboard of expected RAM/UART writes, directed programs
// plus randomized programs.
module tb_phaethon_cpu;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    phaethon_cpu_if bus ();
    phaethon_cpu #(.RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

    localparam int MEM_BYTES = 16384;
    logic [7:0] mem [MEM_BYTES];
    logic [7:0] mm  [MEM_BYTES];

    typedef struct packed {
        logic        kind;   // 0 = RAM write, 1 = UART send
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;
    ev_t exp_q[$];

    int          total = 0;
    int          bad = 0;
    int          uwr_pulses = 0;
    logic [7:0]  last_uwr = 8'h0;
    logic        uwr_prev = 1'b0;
    logic [7:0]  uart_rx_byte = 8'h0;
    logic        ready_rand = 1'b0;
    int          ptr = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_r1 = 32'h0;
    logic [7:0]  alu_ops [10] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h11, 8'h12};

    function automatic int ma(input logic [31:0] a);
        return int'(a[13:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // RAM: one-cycle read latency, write at the strobed posedge
    always @(posedge clk) begin
        if (bus.readReq)
            bus.ramIn <= {mem[ma(bus.ramAddress + 32'd3)], mem[ma(bus.ramAddress + 32'd2)],
                          mem[ma(bus.ramAddress + 32'd1)], mem[ma(bus.ramAddress)]};
        if (bus.writeReq) begin
            mem[ma(bus.ramAddress)]         = bus.ramOut[7:0];
            mem[ma(bus.ramAddress + 32'd1)] = bus.ramOut[15:8];
            mem[ma(bus.ramAddress + 32'd2)] = bus.ramOut[23:16];
            mem[ma(bus.ramAddress + 32'd3)] = bus.ramOut[31:24];
        end
    end

    // monitor: pops the scoreboard on every RAM write or UART send
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            uwr_prev   = 1'b0;
            uwr_pulses = 0;
        end else begin
            if (bus.readReq || bus.writeReq)
                check("strobe_exclusive", 32'(bus.readReq & bus.writeReq), 32'h0);
            if (bus.writeReq || bus.uartWriteReq) begin
                if (bus.uartWriteReq) begin
                    check("uwr_one_cycle", 32'(uwr_prev), 32'h0);
                    uwr_pulses++;
                    last_uwr = bus.uartWriteData;
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected actual=write(uart=%0d addr=0x%08h) required=none",
                             bus.uartWriteReq, bus.ramAddress);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_kind", 32'(bus.uartWriteReq), 32'(e.kind));
                    check("sb_addr", bus.writeReq ? bus.ramAddress : 32'h0, e.addr);
                    check("sb_data", bus.writeReq ? bus.ramOut : {24'h0, bus.uartWriteData}, e.data);
                end
            end
            uwr_prev = bus.uartWriteReq;
        end
    end

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return {mm[ma(a + 32'd3)], mm[ma(a + 32'd2)], mm[ma(a + 32'd1)], mm[ma(a)]};
    endfunction

    function automatic void push_ev(input logic kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // instruction-level reference: runs the loaded program to HALT
    task automatic model_run();
        logic [31:0] r [16];
        logic [31:0] pc, w, im, nxt;
        logic [7:0]  op, i8;
        logic [3:0]  a, b;
        bit          done;
        for (int i = 0; i < MEM_BYTES; i++) mm[i] = mem[i];
        for (int i = 0; i < 16; i++) r[i] = 32'h0;
        pc = 32'h0;
        done = 1'b0;
        exp_pc = 32'hDEAD_BEEF;
        exp_r1 = 32'hDEAD_BEEF;
        for (int step = 0; step < 4000 && !done; step++) begin
            w  = mrd(pc);
            im = mrd(pc + 32'd4);
            op = w[7:0];
            a  = w[11:8];
            b  = w[19:16];
            i8 = w[31:24];
            nxt = pc + 32'd4;
            case (op)
                8'h01: begin r[a] = im; nxt = pc + 32'd8; end
                8'h02: r[a] = r[b];
                8'h03: r[a] = r[a] + r[b];
                8'h04: r[a] = r[a] - r[b];
                8'h05: r[a] = r[a] & r[b];
                8'h06: r[a] = r[a] | r[b];
                8'h07: r[a] = r[a] ^ r[b];
                8'h08: r[a] = r[a] << r[b][4:0];
                8'h09: r[a] = r[a] >> r[b][4:0];
                8'h0A: r[a] = mrd(r[b]);
                8'h0B: begin
                    mm[ma(r[b])]         = r[a][7:0];
                    mm[ma(r[b] + 32'd1)] = r[a][15:8];
                    mm[ma(r[b] + 32'd2)] = r[a][23:16];
                    mm[ma(r[b] + 32'd3)] = r[a][31:24];
                    push_ev(1'b0, r[b], r[a]);
                end
                8'h0C: nxt = im;
                8'h0D: nxt = (r[a] == 32'h0) ? im : pc + 32'd8;
                8'h0E: nxt = (r[a] != 32'h0) ? im : pc + 32'd8;
                8'h0F: r[a] = {24'h0, uart_rx_byte};
                8'h10: push_ev(1'b1, 32'h0, {24'h0, r[a][7:0]});
                8'h11: r[a] = r[a] + {{24{i8[7]}}, i8};
                8'h12: r[a] = (r[a] < r[b]) ? 32'd1 : 32'd0;
                8'hFF: begin done = 1'b1; exp_pc = pc; exp_r1 = r[1]; end
                default: ;
            endcase
            if (!done) pc = nxt;
        end
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [7:0] i8);
        return {i8, 4'h0, b, 4'h0, a, op};
    endfunction

    task automatic emit(input logic [31:0] w);
        mem[ptr]     = w[7:0];
        mem[ptr + 1] = w[15:8];
        mem[ptr + 2] = w[23:16];
        mem[ptr + 3] = w[31:24];
        ptr += 4;
    endtask

    task automatic begin_prog();
        reset = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h0;
        ptr = 0;
    endtask

    task automatic start_prog();
        reset = 1'b1;
        exp_q.delete();
        model_run();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        for (int c = 0; c < budget && !bus.debug3[8]; c++) begin
            @(negedge clk);
            if (ready_rand) bus.uartWriteReady = 1'($urandom_range(0, 1));
        end
        check("halt_reached", 32'(bus.debug3[8]), 32'h1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_final();
        check("final_pc", bus.debug, exp_pc);
        check("final_r1", bus.debug2, exp_r1);
        check("final_debug3", 32'(bus.debug3), 32'h1FF);
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        check("halted_quiet", 32'({bus.readReq, bus.writeReq, bus.uartReadReq, bus.uartWriteReq}), 32'h0);
    endtask

    task automatic gen_random(input int n);
        logic [3:0]  ra, rb;
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1: begin
                    v = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 3));
                    emit(ins(8'h01, ra, 4'h0, 8'h0));
                    emit(v);
                end
                2, 3, 4: emit(ins(alu_ops[$urandom_range(0, 9)], ra, rb, 8'($urandom())));
                5: emit(ins(8'($urandom_range(8'h13, 8'hFE)), ra, rb, 8'h0));
                6: emit(ins(8'h10, ra, 4'h0, 8'h0));
                7: begin
                    emit(ins(8'($urandom_range(8'h0C, 8'h0E)), ra, 4'h0, 8'h0));
                    emit(32'(ptr + 8));
                    emit(ins(8'h11, ra, 4'h0, 8'($urandom())));
                end
                8: begin
                    emit(ins(8'h01, 4'd14, 4'h0, 8'h0));
                    emit(32'h800 + 32'(4 * $urandom_range(0, 15)));
                    emit(ins(8'h0B, ra, 4'd14, 8'h0));
                    emit(ins(8'h0A, rb, 4'd14, 8'h0));
                end
                default: emit(ins(8'h00, ra, rb, 8'h0));
            endcase
        end
        for (int j = 0; j < 14; j++) begin
            emit(ins(8'h01, 4'd14, 4'h0, 8'h0));
            emit(32'hC00 + 32'(4 * j));
            emit(ins(8'h0B, 4'(j), 4'd14, 8'h0));
        end
        emit(ins(8'h10, 4'd15, 4'h0, 8'h0));
        emit(ins(8'hFF, 4'h0, 4'h0, 8'h0));
    endtask

    initial begin
        bus.uartReadAck    = 1'b0;
        bus.uartReadData   = 8'h0;
        bus.uartWriteReady = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_debug", bus.debug, 32'h0);
        check("rst_debug2", bus.debug2, 32'h0);
        check("rst_debug3", 32'(bus.debug3), 32'h0);
        check("rst_strobes", 32'({bus.readReq, bus.writeReq, bus.uartReadReq, bus.uartWriteReq}), 32'h0);

        // MOVI r1,0x12345678; HALT
        begin_prog();
        emit(ins(8'h01, 4'd1, 4'h0, 8'h0)); emit(32'h12345678);
        emit(ins(8'hFF, 4'h0, 4'h0, 8'h0));
        start_prog(); wait_halt(200); check_final();
        check("t1_r1", bus.debug2, 32'h12345678);
        check("t1_pc", bus.debug, 32'h8);

        // ADD / ADDI and SUB wrap
        begin_prog();
        emit(ins(8'h01, 4'd1, 4'h0, 8'h0)); emit(32'd5);
        emit(ins(8'h01, 4'd2, 4'h0, 8'h0)); emit(32'd7);
        emit(ins(8'h03, 4'd1, 4'd2, 8'h0));
        emit(ins(8'h11, 4'd1, 4'h0, 8'hFE));
        emit(ins(8'hFF, 4'h0, 4'h0, 8'h0));
        start_prog(); wait_halt(200); check_final();
        check("t2_add_r1", bus.debug2, 32'd10);
        begin_prog();
        emit(ins(8'h01, 4'd1, 4'h0, 8'h0)); emit(32'd5);
        emit(ins(8'h01, 4'd2, 4'h0, 8'h0)); emit(32'd7);
        emit(ins(8'h04, 4'd1, 4'd2, 8'h0));
        emit(ins(8'hFF, 4'h0, 4'h0, 8'h0));
        start_prog(); wait_halt(200); check_final();
        check("t2_sub_r1", bus.debug2, 32'hFFFFFFFE);

        // ST / LD round trip through RAM
        begin_prog();
        emit(ins(8'h01, 4'd1, 4'h0, 8'h0)); emit(32'hA1B2C3D4);
        emit(ins(8'h01, 4'd2, 4'h0, 8'h0)); emit(32'h400);
        emit(ins(8'h0B, 4'd1, 4'd2, 8'h0));
        emit(ins(8'h01, 4'd1, 4'h0, 8'h0)); emit(32'h0);
        emit(ins(8'h0A, 4'd3, 4'd2, 8'h0));
        emit(ins(8'h02, 4'd1, 4'd3, 8'h0));
        emit(ins(8'hFF, 4'h0, 4'h0, 8'h0));
        start_prog(); wait_halt(300); check_final();
        check("t3_ram_bytes", {mem[16'h403], mem[16'h402], mem[16'h401], mem[16'h400]}, 32'hA1B2C3D4);
        check("t3_r1", bus.debug2, 32'hA1B2C3D4);

        // UARTWR: stall while not ready, then exactly one pulse
        begin_prog();
        emit(ins(8'h01, 4'd1, 4'h0, 8'h0)); emit(32'h41);
        emit(ins(8'h10, 4'd1, 4'h0, 8'h0));
        emit(ins(8'hFF, 4'h0, 4'h0, 8'h0));
        bus.uartWriteReady = 1'b0;
        start_prog();
        repeat (40) @(negedge clk);
        check("t4_stall_pulses", 32'(uwr_pulses), 32'h0);
        check("t4_stall_pc", bus.debug, 32'h8);
        check("t4_stall_not_halted", 32'(bus.debug3[8]), 32'h0);
        bus.uartWriteReady = 1'b1;
        wait_halt(200); check_final();
        check("t4_pulses", 32'(uwr_pulses), 32'h1);
        check("t4_data", 32'(last_uwr), 32'h41);
        start_prog(); wait_halt(200); check_final();
        check("t4_ready_pulses", 32'(uwr_pulses), 32'h1);

        // UARTRD: wait for ack, then ack held high across two reads
        begin_prog();
        emit(ins(8'h0F, 4'd1, 4'h0, 8'h0));
        emit(ins(8'h0F, 4'd2, 4'h0, 8'h0));
        emit(ins(8'h10, 4'd2, 4'h0, 8'h0));
        emit(ins(8'hFF, 4'h0, 4'h0, 8'h0));
        uart_rx_byte = 8'hAB;
        bus.uartReadData = 8'hAB;
        bus.uartReadAck = 1'b0;
        start_prog();
        repeat (20) @(negedge clk);
        check("t5_req_held", 32'(bus.uartReadReq), 32'h1);
        check("t5_wait_pc", bus.debug, 32'h0);
        bus.uartReadAck = 1'b1;
        wait_halt(200); check_final();
        bus.uartReadAck = 1'b0;
        check("t5_r1", bus.debug2, 32'h000000AB);
        check("t5_second_read", 32'(last_uwr), 32'hAB);

        // JNZ countdown, JZ skip, then reset mid-EXEC
        begin_prog();
        emit(ins(8'h01, 4'd1, 4'h0, 8'h0)); emit(32'd3);
        emit(ins(8'h11, 4'd1, 4'h0, 8'hFF));
        emit(ins(8'h0E, 4'd1, 4'h0, 8'h0)); emit(32'd8);
        emit(ins(8'h0D, 4'd1, 4'h0, 8'h0)); emit(32'd32);
        emit(ins(8'h11, 4'd1, 4'h0, 8'h05));
        emit(ins(8'hFF, 4'h0, 4'h0, 8'h0));
        start_prog();
        repeat (8) @(negedge clk);
        check("t6_pre_pc", bus.debug, 32'h8);
        check("t6_pre_r1", bus.debug2, 32'd3);
        reset = 1'b1;
        #1;
        check("t6_abort_pc", bus.debug, 32'h0);
        check("t6_abort_r1", bus.debug2, 32'h0);
        check("t6_abort_outs", 32'({bus.debug3, bus.readReq, bus.writeReq, bus.uartReadReq, bus.uartWriteReq}), 32'h0);
        start_prog(); wait_halt(400); check_final();
        check("t6_pc", bus.debug, 32'd32);
        check("t6_r1", bus.debug2, 32'h0);

        // randomized programs with a randomly toggling sender
        ready_rand = 1'b1;
        for (int t = 0; t < 20; t++) begin
            begin_prog();
            gen_random(30);
            start_prog();
            wait_halt(5000);
            check_final();
        end
        ready_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
